// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- receive FIFO stage between uart_rx and the register block.
//
// Each character from uart_rx is stored with its error flags as
// {BI, FE, PE, data}. The head entry is shown on the read side as a
// first-word-fall-through queue. The block also produces the LSR receive
// status (DR, OE, error-in-FIFO), the FCR trigger-level interrupt condition
// and, optionally, the character timeout. With fifo_en low the queue
// collapses to a single 16450-style holding register.
//
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to build the character
// timeout counter. When it is undefined, timeout is tied low and char_tick
// is ignored.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   wr_valid        push strobe (uart_rx data_ready)
//   wr_data         received character
//   wr_parity_err   parity error for the pushed character
//   wr_framing_err  framing error for the pushed character
//   rd_en           RBR read strobe, pops the head entry
//   fifo_en         FCR[0]; 0 = single holding register mode
//   clear           FCR[1] receiver FIFO reset pulse
//   trig_sel        FCR[7:6] trigger level select (1/4/8/14)
//   lsr_rd          LSR read strobe, clears overrun
//   char_tick       one pulse per character time
//   rd_data         head character (0 when empty)
//   rd_parity_err   head entry PE
//   rd_framing_err  head entry FE
//   rd_break        head entry BI
//   data_avail      LSR[0] DR
//   overrun         LSR[1] OE, sticky
//   fifo_err        LSR[7], at least one stored entry carries an error
//   trigger_hit     receive-data-available interrupt condition
//   timeout         character timeout interrupt condition
//   count           current occupancy
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_parity_err,
  input  logic                     wr_framing_err,
  input  logic                     rd_en,
  input  logic                     fifo_en,
  input  logic                     clear,
  input  logic [1:0]               trig_sel,
  input  logic                     lsr_rd,
  input  logic                     char_tick,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_parity_err,
  output logic                     rd_framing_err,
  output logic                     rd_break,
  output logic                     data_avail,
  output logic                     overrun,
  output logic                     fifo_err,
  output logic                     trigger_hit,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic              brk;
    logic              fe;
    logic              pe;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          new_entry;
  entry_t          head;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   err_cnt;
  logic [CW-1:0]   cap;
  logic [CW-1:0]   trig_lvl;
  logic            fifo_en_q;
  logic            flush;
  logic            full;
  logic            pop;
  logic            push;
  logic            overwrite;
  logic            ovr_set;
  logic            new_err;
  logic            head_err;

  function automatic logic [CW-1:0] clamp_lvl(input int lvl);
    return (lvl > DEPTH) ? CW'(DEPTH) : CW'(lvl);
  endfunction

  // A mode change invalidates the queue layout, so it flushes like clear.
  assign flush = clear || (fifo_en != fifo_en_q);
  assign cap   = fifo_en ? CW'(DEPTH) : CW'(1);
  assign full  = (count >= cap);

  assign pop       = !flush && rd_en && (count != '0);
  assign push      = !flush && wr_valid && (!full || pop);
  // Holding-register mode keeps the newest character on overrun.
  assign overwrite = !flush && wr_valid && full && !pop && !fifo_en;
  assign ovr_set   = !flush && wr_valid && full && !pop;

  always_comb begin
    new_entry.brk  = wr_framing_err && (wr_data == '0);
    new_entry.fe   = wr_framing_err;
    new_entry.pe   = wr_parity_err;
    new_entry.data = wr_data;
  end

  assign head     = (count != '0) ? mem[rd_ptr] : '0;
  assign new_err  = new_entry.brk | new_entry.fe | new_entry.pe;
  assign head_err = head.brk | head.fe | head.pe;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      err_cnt   <= '0;
      overrun   <= 1'b0;
      fifo_en_q <= 1'b0;
    end else begin
      fifo_en_q <= fifo_en;
      // A new overrun wins over a same-cycle LSR read.
      if (ovr_set)     overrun <= 1'b1;
      else if (lsr_rd) overrun <= 1'b0;

      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        err_cnt <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        err_cnt <= err_cnt + CW'(new_err && (push || overwrite))
                           - CW'(head_err && (pop || overwrite));
      end
    end
  end

  // NOTE: the storage array has no reset; the count gates every read, so
  // stale contents are never visible and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push)           mem[wr_ptr] <= new_entry;
    else if (overwrite) mem[rd_ptr] <= new_entry;
  end

  // NOTE: every branch of the case assigns trig_lvl, so no latch is inferred.
  always_comb begin
    case (trig_sel)
      2'b00:   trig_lvl = clamp_lvl(1);
      2'b01:   trig_lvl = clamp_lvl(4);
      2'b10:   trig_lvl = clamp_lvl(8);
      default: trig_lvl = clamp_lvl(14);
    endcase
  end

  assign rd_data        = head.data;
  assign rd_parity_err  = head.pe;
  assign rd_framing_err = head.fe;
  assign rd_break       = head.brk;
  assign data_avail     = (count != '0);
  assign fifo_err       = fifo_en && (err_cnt != '0);
  assign trigger_hit    = fifo_en ? (count >= trig_lvl) : data_avail;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [1:0] to_cnt;
  logic       activity;
  logic       qual_tick;

  assign activity  = push || pop || overwrite;
  assign qual_tick = char_tick && fifo_en && (count != '0) && !activity;

  // The counter parks at 3; the fourth qualifying tick raises timeout,
  // which then holds until the queue is touched or flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt  <= 2'd0;
      timeout <= 1'b0;
    end else if (flush || activity) begin
      to_cnt  <= 2'd0;
      timeout <= 1'b0;
    end else if (qual_tick) begin
      if (to_cnt == 2'd3) timeout <= 1'b1;
      else                to_cnt  <= to_cnt + 2'd1;
    end
  end
`else
  logic unused_char_tick;
  assign unused_char_tick = char_tick;
  assign timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios followed by a
// randomized run, every cycle compared against a queue-based model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int CW     = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid, wr_parity_err, wr_framing_err;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en, fifo_en, clear, lsr_rd, char_tick;
  logic [1:0]        trig_sel;
  logic [DATA_W-1:0] rd_data;
  logic              rd_parity_err, rd_framing_err, rd_break;
  logic              data_avail, overrun, fifo_err, trigger_hit, timeout;
  logic [CW-1:0]     count;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_parity_err(wr_parity_err), .wr_framing_err(wr_framing_err),
    .rd_en(rd_en), .fifo_en(fifo_en), .clear(clear), .trig_sel(trig_sel),
    .lsr_rd(lsr_rd), .char_tick(char_tick),
    .rd_data(rd_data), .rd_parity_err(rd_parity_err),
    .rd_framing_err(rd_framing_err), .rd_break(rd_break),
    .data_avail(data_avail), .overrun(overrun), .fifo_err(fifo_err),
    .trigger_hit(trigger_hit), .timeout(timeout), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } ent_t;

  // Reference model state.
  ent_t q[$];
  bit   m_ovr   = 1'b0;
  bit   m_en_q  = 1'b0;
  int   m_ticks = 0;

  // Mode inputs held between steps, applied with each step.
  bit       en_v = 1'b0;
  bit [1:0] ts_v = 2'b00;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int trig_level(input bit [1:0] ts);
    int tab [4] = '{1, 4, 8, 14};
    return (tab[ts] > DEPTH) ? DEPTH : tab[ts];
  endfunction

  task automatic check_all();
    ent_t h;
    bit   any_err;
    int   sz;
    sz = q.size();
    h  = (sz > 0) ? q[0] : '0;
    any_err = 1'b0;
    foreach (q[i]) if (q[i].bi || q[i].fe || q[i].pe) any_err = 1'b1;
    check("count",       32'(count),        32'(sz));
    check("rd_data",     32'(rd_data),      32'(h.d));
    check("rd_pe",       32'(rd_parity_err),  32'(h.pe));
    check("rd_fe",       32'(rd_framing_err), 32'(h.fe));
    check("rd_break",    32'(rd_break),     32'(h.bi));
    check("data_avail",  32'(data_avail),   32'(sz != 0));
    check("overrun",     32'(overrun),      32'(m_ovr));
    check("fifo_err",    32'(fifo_err),     32'(en_v && any_err));
    check("trigger_hit", 32'(trigger_hit),
          32'(en_v ? (sz >= trig_level(ts_v)) : (sz != 0)));
    check("timeout",     32'(timeout),      32'(TO_ON && (m_ticks >= 4)));
  endtask

  // Model: the queue follows the behavioural rules directly.
  task automatic model_update(input bit wv, input bit [7:0] wd, input bit pe,
                              input bit fe, input bit re, input bit clr,
                              input bit lsr, input bit tick, input bit en);
    bit   fl;
    int   sz;
    bit   full, popped, accepted, ow;
    ent_t e;
    fl     = clr || (en != m_en_q);
    m_en_q = en;
    sz     = q.size();
    if (fl) begin
      q.delete();
      m_ticks = 0;
      if (lsr) m_ovr = 1'b0;
      return;
    end
    full     = sz >= (en ? DEPTH : 1);
    popped   = re && (sz > 0);
    accepted = wv && (!full || popped);
    ow       = wv && full && !popped && !en;
    e        = '{bi: (fe && wd == 8'h00), fe: fe, pe: pe, d: wd};
    if (popped) void'(q.pop_front());
    if (accepted) q.push_back(e);
    else if (ow)  q[0] = e;
    if (wv && full && !popped) m_ovr = 1'b1;
    else if (lsr)              m_ovr = 1'b0;
    if (popped || accepted || ow)      m_ticks = 0;
    else if (tick && en && sz > 0)     m_ticks++;
  endtask

  task automatic step(input bit wv, input bit [7:0] wd, input bit pe,
                      input bit fe, input bit re, input bit clr,
                      input bit lsr, input bit tick);
    @(negedge clk);
    wr_valid = wv; wr_data = wd; wr_parity_err = pe; wr_framing_err = fe;
    rd_en = re; clear = clr; lsr_rd = lsr; char_tick = tick;
    fifo_en = en_v; trig_sel = ts_v;
    @(posedge clk);
    model_update(wv, wd, pe, fe, re, clr, lsr, tick, en_v);
    #1;
    check_all();
  endtask

  task automatic idle();                    step(0, 8'h00, 0, 0, 0, 0, 0, 0); endtask
  task automatic push(input bit [7:0] d);   step(1, d,     0, 0, 0, 0, 0, 0); endtask
  task automatic push_fe(input bit [7:0] d); step(1, d,    0, 1, 0, 0, 0, 0); endtask
  task automatic pop();                     step(0, 8'h00, 0, 0, 1, 0, 0, 0); endtask
  task automatic push_pop(input bit [7:0] d); step(1, d,   0, 0, 1, 0, 0, 0); endtask
  task automatic clr_pulse();               step(0, 8'h00, 0, 0, 0, 1, 0, 0); endtask
  task automatic lsr_read();                step(0, 8'h00, 0, 0, 0, 0, 1, 0); endtask
  task automatic tick();                    step(0, 8'h00, 0, 0, 0, 0, 0, 1); endtask

  initial begin
    rst = 1'b0;
    wr_valid = 0; wr_data = '0; wr_parity_err = 0; wr_framing_err = 0;
    rd_en = 0; fifo_en = 0; clear = 0; trig_sel = 2'b00; lsr_rd = 0;
    char_tick = 0;
    #12;
    check("rst_count",    32'(count),       0);
    check("rst_rd_data",  32'(rd_data),     0);
    check("rst_avail",    32'(data_avail),  0);
    check("rst_overrun",  32'(overrun),     0);
    check("rst_timeout",  32'(timeout),     0);
    check("rst_fifo_err", 32'(fifo_err),    0);
    check("rst_trigger",  32'(trigger_hit), 0);
    @(negedge clk);
    rst = 1'b1;

    // Basic FWFT ordering.
    en_v = 1'b1;
    idle();
    push(8'h41);
    check("tp1_first_visible", 32'(rd_data), 32'h41);
    push(8'h42);
    push(8'h43);
    check("tp1_count3", 32'(count), 3);
    check("tp1_avail",  32'(data_avail), 1);
    pop();
    check("tp1_pop1", 32'(rd_data), 32'h42);
    pop();
    check("tp1_pop2", 32'(rd_data), 32'h43);
    pop();
    check("tp1_empty_count", 32'(count), 0);
    check("tp1_empty_data",  32'(rd_data), 0);
    pop();  // pop on empty is ignored
    check("tp1_empty_pop", 32'(count), 0);

    // Overflow and full push+pop.
    for (int i = 0; i < 17; i++) push(8'(i));
    check("tp2_count16", 32'(count), 16);
    check("tp2_overrun", 32'(overrun), 1);
    lsr_read();
    check("tp2_ovr_clear", 32'(overrun), 0);
    check("tp2_head", 32'(rd_data), 32'h00);
    push_pop(8'h55);
    check("tp3_count16", 32'(count), 16);
    check("tp3_no_ovr",  32'(overrun), 0);
    for (int i = 1; i < 16; i++) begin
      check("tp3_order", 32'(rd_data), 32'(i));
      pop();
    end
    check("tp3_last", 32'(rd_data), 32'h55);
    pop();
    check("tp3_empty", 32'(count), 0);

    // Break / error flag tracking.
    push_fe(8'h00);
    push(8'h7E);
    check("tp4_fifo_err", 32'(fifo_err), 1);
    check("tp4_break",    32'(rd_break), 1);
    check("tp4_fe",       32'(rd_framing_err), 1);
    pop();
    check("tp4_err_gone", 32'(fifo_err), 0);
    check("tp4_data",     32'(rd_data), 32'h7E);
    pop();

    // Trigger level, clear, holding-register mode.
    ts_v = 2'b01;
    for (int i = 0; i < 3; i++) push(8'(8'hA0 + i));
    check("tp5_trig_off", 32'(trigger_hit), 0);
    push(8'hA3);
    check("tp5_trig_on", 32'(trigger_hit), 1);
    clr_pulse();
    check("tp5_clr_count", 32'(count), 0);
    check("tp5_clr_trig",  32'(trigger_hit), 0);
    en_v = 1'b0;
    idle();
    push(8'h12);
    push(8'h34);
    check("tp5_hold_data", 32'(rd_data), 32'h34);
    check("tp5_hold_ovr",  32'(overrun), 1);
    lsr_read();
    pop();

    // Character timeout.
    en_v = 1'b1;
    idle();
    push(8'h99);
    for (int i = 0; i < 3; i++) tick();
    check("tp6_to_early", 32'(timeout), 0);
    tick();
    check("tp6_to_fire", 32'(timeout), 32'(TO_ON));
    pop();
    check("tp6_to_clear", 32'(timeout), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit       wv, pe, fe, re, clr, lsr, tk;
      bit [7:0] d;
      if ($urandom_range(0, 199) == 0) en_v = ~en_v;
      if ($urandom_range(0, 49) == 0)  ts_v = 2'($urandom_range(0, 3));
      wv  = ($urandom_range(0, 9) < 4);
      re  = ($urandom_range(0, 9) < 3);
      clr = ($urandom_range(0, 59) == 0);
      lsr = ($urandom_range(0, 9) == 0);
      tk  = ($urandom_range(0, 4) == 0);
      pe  = ($urandom_range(0, 9) == 0);
      fe  = ($urandom_range(0, 9) == 0);
      d   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      step(wv, d, pe, fe, re, clr, lsr, tk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive FIFO stage directly downstream of uart_rx. It captures each received character and its per-character error flags on the receiver's data_ready pulse, then presents them to the register interface at the head of a first-word-fall-through queue. It generates the LSR receive status (DR, OE, error-in-FIFO), the FCR trigger-level interrupt condition and, optionally, the character timeout. With fifo_en low it acts as the 16450-style single holding register.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
DATA_W, 8, character width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
wr_valid  input  1  one-cycle push strobe, driven by uart_rx data_ready
wr_data  input  DATA_W  received character, from uart_rx data_out
wr_parity_err  input  1  parity error for this character
wr_framing_err  input  1  framing error for this character
rd_en  input  1  RBR read strobe; pops the head entry
fifo_en  input  1  FCR[0]; 0 = single holding register mode
clear  input  1  FCR[1] receiver-FIFO reset pulse
trig_sel  input  2  FCR[7:6] trigger level select
lsr_rd  input  1  LSR read strobe; clears overrun
char_tick  input  1  one pulse per character time (timeout base)
rd_data  output  DATA_W  head character
rd_parity_err  output  1  head entry PE
rd_framing_err  output  1  head entry FE
rd_break  output  1  head entry BI
data_avail  output  1  LSR[0] DR, FIFO non-empty
overrun  output  1  LSR[1] OE, sticky
fifo_err  output  1  LSR[7], at least one stored entry has PE, FE or BI
trigger_hit  output  1  receive-data-available interrupt condition
timeout  output  1  character timeout interrupt condition
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0, asynchronous): pointers=0, count=0, overrun=0, timeout=0, timeout counter=0. All outputs are 0.
- Entry format: {BI, FE, PE, data}. BI is computed at push time as wr_framing_err && (wr_data==0).
- Capacity: DEPTH when fifo_en=1; 1 when fifo_en=0.
- Read side is FWFT. rd_data and the head flags show the head entry whenever count>0, and all read outputs are 0 when empty. A pushed entry is visible on rd_data the cycle after wr_valid.
- Push when not full: the entry is written and count increments.
- Push when full, no pop in the same cycle: the entry is discarded, FIFO contents are unchanged, and overrun is set to 1 on the next cycle.
  - In fifo_en=0 mode this is different: the holding register is overwritten with the new character and overrun is still set.
- Full plus simultaneous wr_valid and rd_en: the pop and push both occur, count is unchanged, no overrun.
- rd_en when empty is ignored. Empty plus simultaneous wr_valid and rd_en: only the push occurs.
- overrun clears on lsr_rd. If lsr_rd coincides with a new overrun event, the set wins.
- Flush sources: clear=1, or any change of fifo_en (edge detected against a registered copy).
  - A flush resets pointers, count, timeout and the timeout counter next cycle.
  - A flush has priority over a same-cycle push or pop; the push is dropped and overrun is not affected.
- fifo_err tracks an internal error-entry counter: +1 on push of an entry with any flag set, -1 on pop of such an entry, 0 on flush. fifo_err = (counter != 0). It is forced to 0 when fifo_en=0.
- trigger_hit: with fifo_en=1, trigger_hit = (count >= L), where trig_sel 00/01/10/11 gives L = 1/4/8/14. For DEPTH<16, L is clamped to DEPTH. With fifo_en=0, trigger_hit = data_avail.
- data_avail = (count != 0). count saturates at DEPTH and never wraps. Pointers wrap modulo DEPTH.

Optional Feature:
Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - A 2-bit counter increments on each char_tick while fifo_en=1, count>0, and there is no push or pop that cycle.
  - Any push, pop or flush zeroes the counter and deasserts timeout.
  - timeout asserts on the fourth consecutive qualifying tick and holds until the next push, pop or flush.
- Undefined: the counter logic is absent, timeout is tied to 0, and char_tick is unused.

Test Plan:
- Reset, then fifo_en=1, push 0x41, 0x42, 0x43 -> rd_data=0x41 one cycle after the first push, count=3, data_avail=1. Three rd_en pops yield 0x41, 0x42, 0x43, then count=0 and rd_data=0.
- fifo_en=1, push 17 characters 0x00..0x10 with no reads -> count=16, overrun=1, 0x10 is lost, and pops return 0x00..0x0F. lsr_rd clears overrun.
- Full FIFO with a same-cycle push of 0x55 and rd_en -> count stays 16, overrun=0, and 0x55 is the last entry popped.
- Push 0x00 with wr_framing_err=1, then 0x7E clean -> fifo_err=1, rd_break=1, rd_framing_err=1. After the first pop, fifo_err=0 and rd_data=0x7E.
- trig_sel=01: push 3 -> trigger_hit=0; push a 4th -> trigger_hit=1. Then pulse clear -> count=0, trigger_hit=0. fifo_en=0: push 0x12 then 0x34 -> rd_data=0x34, overrun=1.
- UART_RX_FIFO_TIMEOUT_EN defined: one entry held, 4 char_ticks -> timeout=1 after the 4th tick. The following rd_en -> timeout=0. With the macro undefined, timeout stays 0.
